// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencing controller owning the HI/LO registers
// Ports: clk/reset (sync, active-high); start_E, MDUop_E, SRCA, SRCB from the E stage;
// Req flushes the E-stage op; busy/md_stall go to the hazard unit; HI/LO are architectural.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_E,
   input  logic [2:0]  MDUop_E,
   input  logic [31:0] SRCA,
   input  logic [31:0] SRCB,
   input  logic        Req,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] HI,
   output logic [31:0] LO
);
   typedef enum logic {IDLE, RUN} state_t;
   state_t      state, state_n;
   logic [31:0] cnt, tmp_hi, tmp_lo;
   logic        tmp_wr, is_md, is_div, accept;
   logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, sq, sr, uq, ur;
   logic [63:0] prod_s, prod_u, res;

   assign is_md    = MDUop_E <= 3'd3;
   assign is_div   = MDUop_E[2:1] == 2'b01;
   assign busy     = state == RUN;
   assign accept   = start_E & ~busy & ~Req;
   assign md_stall = busy | (start_E & is_md & ~Req);

   // low 64 bits of a 64x64 product of sign-extended operands equal the signed 32x32 product
   assign prod_s = {{32{SRCA[31]}}, SRCA} * {{32{SRCB[31]}}, SRCB};
   assign prod_u = {32'd0, SRCA} * {32'd0, SRCB};

   // divisor forced to 1 on zero so the datapath stays defined; the result is discarded anyway
   assign b_div = (SRCB == 32'd0) ? 32'd1 : SRCB;
   assign uq    = SRCA / b_div;
   assign ur    = SRCA % b_div;

   // signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly
   assign a_mag = SRCA[31] ? -SRCA : SRCA;
   assign b_mag = SRCB[31] ? -SRCB : b_div;
   assign q_mag = a_mag / b_mag;
   assign r_mag = a_mag % b_mag;
   assign sq    = (SRCA[31] ^ SRCB[31]) ? -q_mag : q_mag;
   assign sr    = SRCA[31] ? -r_mag : r_mag;

   always_comb begin
      res = (MDUop_E == 3'd0) ? prod_s :
            (MDUop_E == 3'd1) ? prod_u :
            (MDUop_E == 3'd2) ? {sr, sq} : {ur, uq};
   end

   always_comb begin
      state_n = state;
      state_n = (state == IDLE) ? ((accept & is_md) ? RUN : IDLE) : ((cnt == 32'd1) ? IDLE : RUN);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= 32'd0;
         tmp_hi <= 32'd0;
         tmp_lo <= 32'd0;
         tmp_wr <= 1'b0;
         HI     <= 32'd0;
         LO     <= 32'd0;
      end else begin
         state <= state_n;
         if (accept & is_md) begin
            {tmp_hi, tmp_lo} <= res;
            tmp_wr           <= ~(is_div & (SRCB == 32'd0));
            cnt              <= is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
         end else if (busy) begin
            cnt <= cnt - 32'd1;
         end
         if (busy & (cnt == 32'd1) & tmp_wr) begin
            HI <= tmp_hi;
            LO <= tmp_lo;
         end
         if (accept & (MDUop_E == 3'd4)) HI <= SRCA;
         if (accept & (MDUop_E == 3'd5)) LO <= SRCA;
      end
   end
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: scoreboard bench for mdu_ctrl
module tb_mdu_ctrl;
   logic        clk = 0, reset = 1, start_E = 0, Req = 0;
   logic [2:0]  MDUop_E = 0;
   logic [31:0] SRCA = 0, SRCB = 0;
   logic        busy, md_stall;
   logic [31:0] HI, LO;
   logic [63:0] sb[$];
   logic [31:0] m_hi = 0, m_lo = 0;
   int          total = 0, bad = 0;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start_E(start_E), .MDUop_E(MDUop_E),
      .SRCA(SRCA), .SRCB(SRCB), .Req(Req), .busy(busy), .md_stall(md_stall),
      .HI(HI), .LO(LO)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] cur);
      longint          sa = $signed(a);
      longint          sb_ = $signed(b);
      longint unsigned ua = a;
      longint unsigned ub = b;
      longint          sq, sr;
      longint unsigned uq, ur;
      if (op == 3'd0) return 64'(sa * sb_);
      if (op == 3'd1) return ua * ub;
      if (b == 32'd0) return cur;
      if (op == 3'd2) begin
         sq = sa / sb_;
         sr = sa % sb_;
         return {sr[31:0], sq[31:0]};
      end
      uq = ua / ub;
      ur = ua % ub;
      return {ur[31:0], uq[31:0]};
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq);
      @(negedge clk);
      start_E = 1; MDUop_E = op; SRCA = a; SRCB = b; Req = rq;
      #1;
      check("stall_at_issue", 64'(md_stall), 64'((op <= 3'd3) && !rq));
      if (!rq) begin
         if (op <= 3'd3) sb.push_back(calc(op, a, b, {m_hi, m_lo}));
         else if (op == 3'd4) m_hi = a;
         else if (op == 3'd5) m_lo = a;
      end
      @(posedge clk);
      #1;
      start_E = 0; Req = 0; MDUop_E = 0; SRCA = 0; SRCB = 0;
   endtask

   // inj: 0 none, 1 pulse Req mid-run, 2 mthi issued while busy
   task automatic finish(input int n, input int inj);
      int          cnt = 0;
      logic [63:0] exp;
      @(negedge clk);
      while (busy && cnt < 100) begin
         cnt++;
         if (cnt == 2 && inj == 1) Req = 1;
         if (cnt == 2 && inj == 2) begin
            start_E = 1; MDUop_E = 3'd4; SRCA = 32'hABCD;
            #1;
            check("stall_while_busy", 64'(md_stall), 64'd1);
         end
         if (cnt == 3) begin
            Req = 0; start_E = 0; MDUop_E = 0; SRCA = 0;
         end
         @(negedge clk);
      end
      check("busy_cycles", 64'(cnt), 64'(n));
      if (sb.size() == 0) begin
         check("sb_nonempty", 64'd0, 64'd1);
      end else begin
         exp = sb.pop_front();
         {m_hi, m_lo} = exp;
         check("hi_lo", {HI, LO}, exp);
      end
   endtask

   task automatic check_idle(input string tag);
      @(negedge clk);
      check(tag, {31'd0, busy, HI, LO}, {32'd0, m_hi, m_lo});
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 0;
      @(negedge clk);
      check("reset_state", {30'd0, busy, md_stall, HI, LO}, 96'd0);

      issue(3'd0, 32'hFFFFFFFD, 32'd5, 0);         finish(5, 0);
      issue(3'd1, 32'hFFFFFFFF, 32'd2, 0);         finish(5, 0);
      issue(3'd0, 32'hFFFFFFFF, 32'd2, 0);         finish(5, 0);
      issue(3'd2, 32'hFFFFFFF9, 32'd2, 0);         finish(10, 0);
      issue(3'd3, 32'd7, 32'd2, 0);                finish(10, 0);
      issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 0);  finish(10, 0);
      issue(3'd3, 32'hDEADBEEF, 32'h00001234, 0);  finish(10, 0);

      issue(3'd4, 32'h11, 32'd0, 0);               check_idle("mthi");
      issue(3'd5, 32'h22, 32'd0, 0);               check_idle("mtlo");
      issue(3'd2, 32'd1234, 32'd0, 0);             finish(10, 0);
      issue(3'd3, 32'd99, 32'd0, 0);               finish(10, 0);

      issue(3'd0, 32'd9, 32'd9, 1);                check_idle("req_drop");
      issue(3'd4, 32'h5555, 32'd0, 1);             check_idle("req_drop_mthi");
      issue(3'd6, 32'h7777, 32'd3, 0);             check_idle("reserved6");
      issue(3'd7, 32'h7777, 32'd3, 0);             check_idle("reserved7");

      issue(3'd1, 32'h12345678, 32'h9ABCDEF0, 0);  finish(5, 1);
      issue(3'd2, 32'hFFFF0000, 32'd7, 0);         finish(10, 1);
      issue(3'd0, 32'h00012345, 32'hFFFFF000, 0);  finish(5, 2);

      issue(3'd2, 32'd100, 32'd7, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      reset = 0;
      sb.delete();
      m_hi = 0; m_lo = 0;
      check("reset_mid_op", {31'd0, busy, HI, LO}, 96'd0);
      repeat (12) @(negedge clk);
      check("no_late_write", {31'd0, busy, HI, LO}, 96'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end
endmodule
